// File: rtl/ternary_systolic_sequencer_v3_if.sv
// Command, buffer-port and array-control bundle between the tile sequencer and its neighbours.
// slave = sequencer side, master = command source / buffer side.
interface ternary_systolic_sequencer_v3_if #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 12
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              start;
  logic [15:0]       layer_m;
  logic [15:0]       layer_n;
  logic [15:0]       layer_k;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err_cfg;
  logic              wgt_rd_en;
  logic [ADDR_W-1:0] wgt_rd_addr;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_rd_addr;
  logic [ROWS-1:0]   act_row_mask;
  logic [COLS-1:0]   col_mask;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic              out_accum;
  logic              array_enable;
  logic              array_weight_load;
  logic [ROW_W-1:0]  array_weight_row;
  logic              swap_weight_banks;
  logic              swap_act_banks;
  logic              tile_done;

  modport slave (
    input  start, layer_m, layer_n, layer_k, mem_ready,
    output busy, done, err_cfg, wgt_rd_en, wgt_rd_addr, act_rd_en, act_rd_addr,
           act_row_mask, col_mask, out_wr_en, out_wr_addr, out_accum,
           array_enable, array_weight_load, array_weight_row,
           swap_weight_banks, swap_act_banks, tile_done
  );

  modport master (
    output start, layer_m, layer_n, layer_k, mem_ready,
    input  busy, done, err_cfg, wgt_rd_en, wgt_rd_addr, act_rd_en, act_rd_addr,
           act_row_mask, col_mask, out_wr_en, out_wr_addr, out_accum,
           array_enable, array_weight_load, array_weight_row,
           swap_weight_banks, swap_act_banks, tile_done
  );
endinterface

// File: rtl/ternary_systolic_sequencer_v3.sv
// Weight-stationary ROWSxCOLS tile sequencer: k-inner/n/m tiling, edge masks, accumulate on k>0.
// Outputs are combinational from the registered state; mem_ready low freezes all active phases.
module ternary_systolic_sequencer_v3 #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int M_TILE   = 8,
  parameter int ACC_BITS = 32,
  parameter int ADDR_W   = 12,
  parameter int MAC_PIPE = 1
) (
  input  logic clk,
  input  logic rst,
  ternary_systolic_sequencer_v3_if.slave bus
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(M_TILE + ROWS);
  typedef logic [39:0] wide_t;

  if (MAC_PIPE != 1 && MAC_PIPE != 2) begin : g_bad_mac_pipe
    $error("MAC_PIPE must be 1 or 2");
  end
  // A psum must hold a full column of int8 x ternary products.
  if (ACC_BITS < 9 + $clog2(ROWS)) begin : g_bad_acc_bits
    $error("ACC_BITS too narrow for ROWS");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_FLUSH, S_DRAIN, S_NEXT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      m_q, m_d, n_q, n_d, k_q, k_d, kt_q, kt_d;
  logic [15:0]      tile_m_q, tile_m_d, tile_n_q, tile_n_d, tile_k_q, tile_k_d;
  logic [15:0]      n_idx_q, n_idx_d, k_idx_q, k_idx_d;
  logic             err_q, err_d;
  logic             run;
  wide_t            wgt_addr_w, act_addr_w, out_addr_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kt_q     <= '0;
      tile_m_q <= '0;
      tile_n_q <= '0;
      tile_k_q <= '0;
      n_idx_q  <= '0;
      k_idx_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kt_q     <= kt_d;
      tile_m_q <= tile_m_d;
      tile_n_q <= tile_n_d;
      tile_k_q <= tile_k_d;
      n_idx_q  <= n_idx_d;
      k_idx_q  <= k_idx_d;
      err_q    <= err_d;
    end
  end

  // Full-width address arithmetic; buffers see the value modulo 2^ADDR_W.
  assign wgt_addr_w = wide_t'(n_idx_q) * wide_t'(kt_q) * wide_t'(ROWS)
                    + wide_t'(tile_k_q) + wide_t'(cnt_q);
  assign act_addr_w = (wide_t'(tile_m_q) + wide_t'(cnt_q)) * wide_t'(kt_q) + wide_t'(k_idx_q);
  assign out_addr_w = (wide_t'(tile_m_q) + wide_t'(cnt_q)) * wide_t'(n_q) + wide_t'(tile_n_q);
  assign run        = bus.mem_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    kt_d     = kt_q;
    tile_m_d = tile_m_q;
    tile_n_d = tile_n_q;
    tile_k_d = tile_k_q;
    n_idx_d  = n_idx_q;
    k_idx_d  = k_idx_q;
    err_d    = err_q;

    bus.busy              = (state_q != S_IDLE) && !(state_q == S_DONE && err_q);
    bus.done              = 1'b0;
    bus.err_cfg           = 1'b0;
    bus.wgt_rd_en         = 1'b0;
    bus.wgt_rd_addr       = '0;
    bus.act_rd_en         = 1'b0;
    bus.act_rd_addr       = '0;
    bus.out_wr_en         = 1'b0;
    bus.out_wr_addr       = '0;
    bus.out_accum         = 1'b0;
    bus.array_enable      = 1'b0;
    bus.array_weight_load = 1'b0;
    bus.array_weight_row  = '0;
    bus.swap_weight_banks = 1'b0;
    bus.swap_act_banks    = 1'b0;
    bus.tile_done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d      = bus.layer_m;
          n_d      = bus.layer_n;
          k_d      = bus.layer_k;
          kt_d     = 16'((17'(bus.layer_k) + 17'(ROWS - 1)) / 17'(ROWS));
          tile_m_d = '0;
          tile_n_d = '0;
          tile_k_d = '0;
          n_idx_d  = '0;
          k_idx_d  = '0;
          cnt_d    = '0;
          err_d    = (bus.layer_m == 16'd0) || (bus.layer_n == 16'd0) || (bus.layer_k == 16'd0);
          state_d  = err_d ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.wgt_rd_addr      = wgt_addr_w[ADDR_W-1:0];
        bus.array_weight_row = cnt_q[ROW_W-1:0];
        if (run) begin
          bus.wgt_rd_en         = 1'b1;
          bus.array_weight_load = 1'b1;
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            cnt_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        bus.act_rd_addr = act_addr_w[ADDR_W-1:0];
        if (run) begin
          bus.array_enable = 1'b1;
          bus.act_rd_en    = (cnt_q < CNT_W'(M_TILE));
          if (cnt_q == CNT_W'(M_TILE + ROWS - 2)) begin
            cnt_d   = '0;
            state_d = (MAC_PIPE == 2) ? S_FLUSH : S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (run) begin
          bus.array_enable = 1'b1;
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        bus.out_wr_addr = out_addr_w[ADDR_W-1:0];
        bus.out_accum   = (tile_k_q != 16'd0);
        if (run) begin
          bus.array_enable = 1'b1;
          bus.out_wr_en    = (17'(tile_m_q) + 17'(cnt_q)) < 17'(m_q);
          if (cnt_q == CNT_W'(M_TILE - 1)) begin
            cnt_d   = '0;
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_NEXT: begin
        bus.tile_done         = 1'b1;
        bus.swap_weight_banks = 1'b1;
        bus.swap_act_banks    = 1'b1;
        cnt_d                 = '0;
        state_d               = S_LOAD;
        // k is the innermost loop, then n, then m.
        if ((17'(tile_k_q) + 17'(ROWS)) < 17'(k_q)) begin
          tile_k_d = tile_k_q + 16'(ROWS);
          k_idx_d  = k_idx_q + 16'd1;
        end else begin
          tile_k_d = '0;
          k_idx_d  = '0;
          if ((17'(tile_n_q) + 17'(COLS)) < 17'(n_q)) begin
            tile_n_d = tile_n_q + 16'(COLS);
            n_idx_d  = n_idx_q + 16'd1;
          end else begin
            tile_n_d = '0;
            n_idx_d  = '0;
            if ((17'(tile_m_q) + 17'(M_TILE)) < 17'(m_q)) begin
              tile_m_d = tile_m_q + 16'(M_TILE);
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.err_cfg = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.act_row_mask = '0;
    bus.col_mask     = '0;
    if (state_q != S_IDLE) begin
      for (int r = 0; r < ROWS; r++) begin
        bus.act_row_mask[r] = (17'(tile_k_q) + 17'(r)) < 17'(k_q);
      end
      for (int c = 0; c < COLS; c++) begin
        bus.col_mask[c] = (17'(tile_n_q) + 17'(c)) < 17'(n_q);
      end
    end
  end
endmodule

// File: tb/tb_ternary_systolic_sequencer_v3.sv
// Directed bench: two 4x4 sequencers (MAC_PIPE 1 and 2) driven in lockstep, traces checked against hand-computed sequences.
module tb_ternary_systolic_sequencer_v3;
  logic        clk = 1'b0;
  logic        rst, start, mrdy;
  logic [15:0] lm, ln, lk;

  always #5 clk = ~clk;

  ternary_systolic_sequencer_v3_if #(.ROWS(4), .COLS(4), .ADDR_W(12)) if1 ();
  ternary_systolic_sequencer_v3_if #(.ROWS(4), .COLS(4), .ADDR_W(12)) if2 ();

  assign if1.start = start;  assign if2.start = start;
  assign if1.layer_m = lm;   assign if2.layer_m = lm;
  assign if1.layer_n = ln;   assign if2.layer_n = ln;
  assign if1.layer_k = lk;   assign if2.layer_k = lk;
  assign if1.mem_ready = mrdy; assign if2.mem_ready = mrdy;

  ternary_systolic_sequencer_v3 #(.ROWS(4), .COLS(4), .M_TILE(4), .ACC_BITS(32), .ADDR_W(12), .MAC_PIPE(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  ternary_systolic_sequencer_v3 #(.ROWS(4), .COLS(4), .M_TILE(4), .ACC_BITS(32), .ADDR_W(12), .MAC_PIPE(2))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_tests = 0, n_fail = 0;
  int cyc = 0, cyc0 = 0, mon_t;
  bit rec = 1'b0;
  int wgt_q[$], act_q[$], out_q[$], acc_q[$], cmask_q[$], rmask_q[$], e[$];
  int done_cyc, err_at_done, busy_seen, busy_after, first_load, n_arr, n_td, n_sw, n_sa;
  int swap_coll, stall_act, done2_cyc, first_wr2, n_arr2;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic logic [63:0] snap();
    return 64'({if1.busy, if1.done, if1.err_cfg, if1.wgt_rd_en, if1.wgt_rd_addr, if1.act_rd_en,
                if1.act_rd_addr, if1.act_row_mask, if1.col_mask, if1.out_wr_en, if1.out_wr_addr,
                if1.out_accum, if1.array_enable, if1.array_weight_load, if1.array_weight_row,
                if1.swap_weight_banks, if1.swap_act_banks, if1.tile_done});
  endfunction

  always @(negedge clk) begin
    if (rec) begin
      mon_t = cyc - cyc0;
      if (if1.wgt_rd_en) wgt_q.push_back(int'(if1.wgt_rd_addr));
      if (if1.act_rd_en) act_q.push_back(int'(if1.act_rd_addr));
      if (if1.out_wr_en) begin
        out_q.push_back(int'(if1.out_wr_addr));
        acc_q.push_back(int'(if1.out_accum));
      end
      if (if1.tile_done) begin
        n_td++;
        cmask_q.push_back(int'(if1.col_mask));
        rmask_q.push_back(int'(if1.act_row_mask));
      end
      if (if1.swap_weight_banks) n_sw++;
      if (if1.swap_act_banks) n_sa++;
      if ((if1.swap_weight_banks || if1.swap_act_banks) &&
          (if1.wgt_rd_en || if1.act_rd_en || if1.out_wr_en)) swap_coll++;
      if (!mrdy && (if1.array_enable || if1.wgt_rd_en || if1.act_rd_en || if1.out_wr_en)) stall_act++;
      if (done_cyc >= 0 && mon_t == done_cyc + 1) busy_after = int'(if1.busy);
      if (if1.done && done_cyc < 0) begin
        done_cyc    = mon_t;
        err_at_done = int'(if1.err_cfg);
      end
      if (if1.busy) busy_seen = 1;
      if (if1.wgt_rd_en && first_load < 0) first_load = mon_t;
      if (if1.array_enable) n_arr++;
      if (if2.done && done2_cyc < 0) done2_cyc = mon_t;
      if (if2.out_wr_en && first_wr2 < 0) first_wr2 = mon_t;
      if (if2.array_enable) n_arr2++;
    end
  end

  // Issues one command at relative cycle 0; extra start pulses at ea/eb must be ignored.
  task automatic run_cmd(input int m, input int n, input int k, input int stall_at,
                         input int stall_len, input int ea, input int eb);
    wgt_q.delete(); act_q.delete(); out_q.delete(); acc_q.delete(); cmask_q.delete(); rmask_q.delete();
    done_cyc = -1; done2_cyc = -1; first_load = -1; first_wr2 = -1; busy_after = -1;
    err_at_done = -1; busy_seen = 0; n_arr = 0; n_arr2 = 0; n_td = 0; n_sw = 0; n_sa = 0;
    swap_coll = 0; stall_act = 0;
    @(posedge clk); #1;
    lm = 16'(m); ln = 16'(n); lk = 16'(k);
    cyc0 = cyc;
    rec  = 1'b1;
    for (int t = 0; t < 600; t++) begin
      start = (t == 0) || (t == ea) || (t == eb);
      if (t > 0 && start) begin lm = 16'd2; ln = 16'd2; lk = 16'd2; end
      mrdy = !(t >= stall_at && t < stall_at + stall_len);
      @(posedge clk); #1;
      if (done_cyc >= 0 && done2_cyc >= 0) break;
    end
    start = 1'b0;
    mrdy  = 1'b1;
    @(posedge clk); #1;
    rec = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mrdy = 1'b1; lm = '0; ln = '0; lk = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", snap(), 64'd0);

    // 4x4x4, single tile; restart attempts while busy and on the done cycle
    run_cmd(4, 4, 4, 1000, 0, 6, 17);
    check("s1_done_cyc", 64'(done_cyc), 64'd17);
    check("s1_err", 64'(err_at_done), 64'd0);
    check("s1_first_load", 64'(first_load), 64'd1);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(i);
    check_seq("s1_wgt", wgt_q, e);
    check_seq("s1_act", act_q, e);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(i * 4);
    check_seq("s1_out", out_q, e);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(0);
    check_seq("s1_accum", acc_q, e);
    check("s1_tile_done", 64'(n_td), 64'd1);
    check("s1_swap_w", 64'(n_sw), 64'd1);
    check("s1_swap_a", 64'(n_sa), 64'd1);
    check("s1_swap_coll", 64'(swap_coll), 64'd0);
    check("s1_arr_cycles", 64'(n_arr), 64'd11);
    check("s1_busy_seen", 64'(busy_seen), 64'd1);
    check("s1_busy_after", 64'(busy_after), 64'd0);
    check("p2_done_cyc", 64'(done2_cyc), 64'd21);
    check("p2_first_wr", 64'(first_wr2), 64'd16);
    check("p2_arr_cycles", 64'(n_arr2), 64'd15);

    // K=8: two k-tiles, second drain accumulates
    run_cmd(4, 4, 8, 1000, 0, -1, -1);
    check("s2_done_cyc", 64'(done_cyc), 64'd33);
    e.delete(); for (int i = 0; i < 8; i++) e.push_back(i);
    check_seq("s2_wgt", wgt_q, e);
    e.delete(); for (int i = 0; i < 8; i++) e.push_back((i % 4) * 2 + i / 4);
    check_seq("s2_act", act_q, e);
    e.delete(); for (int i = 0; i < 8; i++) e.push_back(i / 4);
    check_seq("s2_accum", acc_q, e);
    check("s2_tile_done", 64'(n_td), 64'd2);

    // M=6 N=5 K=4: partial n and m edges
    run_cmd(6, 5, 4, 1000, 0, -1, -1);
    check("s3_done_cyc", 64'(done_cyc), 64'd65);
    e.delete(); for (int i = 0; i < 16; i++) e.push_back(i % 8);
    check_seq("s3_wgt", wgt_q, e);
    e.delete(); for (int i = 0; i < 16; i++) e.push_back((i / 8) * 4 + i % 4);
    check_seq("s3_act", act_q, e);
    e.delete();
    for (int i = 0; i < 4; i++) e.push_back(i * 5);
    for (int i = 0; i < 4; i++) e.push_back(i * 5 + 4);
    e.push_back(20); e.push_back(25); e.push_back(24); e.push_back(29);
    check_seq("s3_out", out_q, e);
    e.delete(); e.push_back(15); e.push_back(1); e.push_back(15); e.push_back(1);
    check_seq("s3_colmask", cmask_q, e);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(15);
    check_seq("s3_rowmask", rmask_q, e);

    // K=3: partial row mask
    run_cmd(4, 4, 3, 1000, 0, -1, -1);
    check("s4_done_cyc", 64'(done_cyc), 64'd17);
    e.delete(); e.push_back(7);
    check_seq("s4_rowmask", rmask_q, e);
    e.delete(); e.push_back(15);
    check_seq("s4_colmask", cmask_q, e);

    // mem_ready low in cycles 7..9
    run_cmd(4, 4, 4, 7, 3, -1, -1);
    check("s5_done_cyc", 64'(done_cyc), 64'd20);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(i);
    check_seq("s5_wgt", wgt_q, e);
    check_seq("s5_act", act_q, e);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(i * 4);
    check_seq("s5_out", out_q, e);
    check("s5_stall_activity", 64'(stall_act), 64'd0);
    check("s5_arr_cycles", 64'(n_arr), 64'd11);

    // K=0: immediate error completion
    run_cmd(4, 4, 0, 1000, 0, -1, -1);
    check("s6_done_cyc", 64'(done_cyc), 64'd1);
    check("s6_err", 64'(err_at_done), 64'd1);
    check("s6_busy_seen", 64'(busy_seen), 64'd0);
    check("s6_rd_count", 64'(wgt_q.size() + act_q.size()), 64'd0);

    // Reset in cycle 8 of a running command
    @(posedge clk); #1;
    lm = 16'd4; ln = 16'd4; lk = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("s7_busy_before_rst", 64'(if1.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s7_outputs_after_rst", snap(), 64'd0);
    run_cmd(4, 4, 4, 1000, 0, -1, -1);
    check("s7_done_cyc", 64'(done_cyc), 64'd17);
    e.delete(); for (int i = 0; i < 4; i++) e.push_back(i);
    check_seq("s7_wgt", wgt_q, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
